// File: rtl/mem_loader.sv
// Program loader: turns a length-prefixed byte stream into big-endian words written to
// consecutive memory addresses. The CPU is held in reset until the image is in place.
module mem_loader #(
  parameter int unsigned ADDR_WIDTH = 7,
  parameter int unsigned BASE_ADDR  = 0,
  parameter int unsigned RST_HOLD   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  cpu_rstn,
  output logic                  done,
  output logic                  err,
  output logic [15:0]           words_loaded
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned LEN_W  = 16;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned HOLD_W = 8;
  localparam int unsigned DEPTH  = 2 ** ADDR_WIDTH;

  localparam logic [ADDR_WIDTH-1:0] BASE      = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [HOLD_W-1:0]     HOLD_LAST = HOLD_W'(RST_HOLD - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_WRITE,
    S_HOLD,
    S_ERR
  } state_t;

  state_t                    state_q;
  logic [LEN_W-1:0]          len_q;
  logic [3*BYTE_W-1:0]       shift_q;
  logic [1:0]                byte_cnt_q;
  logic [HOLD_W-1:0]         hold_cnt_q;
  logic                      in_ready_q;
  logic                      mem_we_q;
  logic [ADDR_WIDTH-1:0]     mem_addr_q;
  logic [WORD_W-1:0]         mem_wdata_q;
  logic                      cpu_rstn_q;
  logic                      done_q;
  logic                      err_q;
  logic [LEN_W-1:0]          words_q;

  logic                      xfer_c;
  logic                      len_too_long_c;
  logic [LEN_W-1:0]          len_d;
  logic [WORD_W-1:0]         word_d;
  logic [LEN_W-1:0]          words_d;

  // Handshake, completed length, completed word and next word count.
  always_comb begin
    xfer_c         = in_valid & in_ready_q;
    len_d          = {len_q[LEN_W-1:BYTE_W], in_data};
    word_d         = {shift_q, in_data};
    words_d        = words_q + LEN_W'(1);
    len_too_long_c = 32'(len_d) > DEPTH;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      shift_q     <= '0;
      byte_cnt_q  <= '0;
      hold_cnt_q  <= '0;
      in_ready_q  <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= BASE;
      mem_wdata_q <= '0;
      cpu_rstn_q  <= 1'b1;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      words_q     <= '0;
    end else begin
      mem_we_q <= 1'b0;
      done_q   <= 1'b0;
      case (state_q)
        S_IDLE, S_ERR: begin
          if (start) begin
            state_q    <= S_LEN_HI;
            in_ready_q <= 1'b1;
            cpu_rstn_q <= 1'b0;
            err_q      <= 1'b0;
            words_q    <= '0;
            mem_addr_q <= BASE;
          end
        end
        S_LEN_HI: begin
          if (xfer_c) begin
            len_q[LEN_W-1:BYTE_W] <= in_data;
            state_q               <= S_LEN_LO;
          end
        end
        S_LEN_LO: begin
          if (xfer_c) begin
            len_q <= len_d;
            if (len_d == '0) begin
              state_q    <= S_HOLD;
              in_ready_q <= 1'b0;
              hold_cnt_q <= '0;
            end else if (len_too_long_c) begin
              state_q    <= S_ERR;
              in_ready_q <= 1'b0;
              err_q      <= 1'b1;
            end else begin
              state_q    <= S_DATA;
              byte_cnt_q <= '0;
            end
          end
        end
        // First byte of a word lands in bits 31:24 after four shifts.
        S_DATA: begin
          if (xfer_c) begin
            shift_q    <= {shift_q[2*BYTE_W-1:0], in_data};
            byte_cnt_q <= byte_cnt_q + 2'd1;
            if (byte_cnt_q == 2'd3) begin
              state_q     <= S_WRITE;
              in_ready_q  <= 1'b0;
              mem_we_q    <= 1'b1;
              mem_wdata_q <= word_d;
            end
          end
        end
        S_WRITE: begin
          mem_addr_q <= mem_addr_q + ADDR_WIDTH'(1);
          words_q    <= words_d;
          if (words_d == len_q) begin
            state_q    <= S_HOLD;
            hold_cnt_q <= '0;
          end else begin
            state_q    <= S_DATA;
            in_ready_q <= 1'b1;
          end
        end
        S_HOLD: begin
          if (hold_cnt_q == HOLD_LAST) begin
            state_q    <= S_IDLE;
            cpu_rstn_q <= 1'b1;
            done_q     <= 1'b1;
          end else begin
            hold_cnt_q <= hold_cnt_q + HOLD_W'(1);
          end
        end
        default: begin
          state_q    <= S_IDLE;
          in_ready_q <= 1'b0;
          cpu_rstn_q <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready     = in_ready_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign cpu_rstn     = cpu_rstn_q;
  assign done         = done_q;
  assign err          = err_q;
  assign words_loaded = words_q;

endmodule

// File: tb/tb_mem_loader.sv
// Bench for mem_loader: table of load scenarios, hand sequences for abort/ignored start,
// and random loads checked against a stream-level model of the expected writes.
module tb_mem_loader;

  localparam int unsigned ADDR_WIDTH = 7;
  localparam int unsigned BASE_ADDR  = 0;
  localparam int unsigned RST_HOLD   = 4;
  localparam int unsigned DEPTH      = 2 ** ADDR_WIDTH;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  start;
  logic [7:0]            in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_wdata;
  logic                  cpu_rstn;
  logic                  done;
  logic                  err;
  logic [15:0]           words_loaded;

  always #5 clk = ~clk;

  mem_loader #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .BASE_ADDR (BASE_ADDR),
    .RST_HOLD  (RST_HOLD)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .cpu_rstn    (cpu_rstn),
    .done        (done),
    .err         (err),
    .words_loaded(words_loaded)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Observed activity, sampled on the falling edge.
  int                    cyc = 0;
  int                    n_we = 0;
  int                    n_done = 0;
  int                    n_xfer = 0;
  int                    low_cnt = 0;
  int                    done_cyc = 0;
  int                    last_xfer_cyc = 0;
  int                    start_cyc = 0;
  int                    wr_cyc[$];
  logic [ADDR_WIDTH-1:0] wr_addr[$];
  logic [31:0]           wr_data[$];
  logic                  prev_rstn = 1'b1;

  always @(negedge clk) begin
    cyc++;
    if (in_valid && in_ready) begin
      n_xfer++;
      last_xfer_cyc = cyc;
    end
    if (mem_we) begin
      n_we++;
      wr_cyc.push_back(cyc);
      wr_addr.push_back(mem_addr);
      wr_data.push_back(mem_wdata);
      chk("we_while_ready", 64'(in_ready), 64'(0));
    end
    if (done) begin
      n_done++;
      done_cyc = cyc;
      chk("done_vs_rstn_edge", 64'({prev_rstn, cpu_rstn}), 64'(2'b01));
    end
    if (!cpu_rstn) low_cnt++;
    prev_rstn = cpu_rstn;
  end

  function automatic void clear_mon();
    n_we = 0; n_done = 0; n_xfer = 0; low_cnt = 0;
    wr_cyc.delete(); wr_addr.delete(); wr_data.delete();
  endfunction

  // Stream bytes of the load under test (data only, length sent separately).
  logic [7:0] byte_q[$];

  function automatic logic [31:0] model_word(input int i);
    return {byte_q[4*i], byte_q[4*i+1], byte_q[4*i+2], byte_q[4*i+3]};
  endfunction

  function automatic int pick_stall(input int stall, input bit rnd);
    return rnd ? int'($urandom_range(0, stall)) : stall;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int stall);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b0;
    repeat (stall) tick();
    in_valid = 1'b1;
    in_data  = b;
    for (int t = 0; t < 1000 && !ok; t++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    chk("byte_accepted", 64'(ok), 64'(1));
  endtask

  task automatic pulse_start();
    start     = 1'b1;
    start_cyc = cyc + 1;
    tick();
    start     = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 3000 && !ok; t++) begin
      @(negedge clk);
      if (done) ok = 1'b1;
      tick();
    end
  endtask

  task automatic run_load(input string tag, input logic [15:0] len, input int stall,
                          input bit rnd, input bit exp_err, input int exp_words,
                          input logic [31:0] exp_w0);
    bit ok;
    int n;
    int last_evt;
    n = int'(len);
    clear_mon();
    pulse_start();
    low_cnt = 0;
    chk({tag, "_start_err"}, 64'(err), 64'(0));
    chk({tag, "_start_rstn"}, 64'(cpu_rstn), 64'(0));
    chk({tag, "_start_ready"}, 64'(in_ready), 64'(1));
    chk({tag, "_start_words"}, 64'(words_loaded), 64'(0));
    chk({tag, "_start_addr"}, 64'(mem_addr), 64'(BASE_ADDR));
    send_byte(len[15:8], pick_stall(stall, rnd));
    send_byte(len[7:0], pick_stall(stall, rnd));
    if (exp_err) begin
      in_valid = 1'b1;
      in_data  = 8'h55;
      repeat (4) tick();
      chk({tag, "_err"}, 64'(err), 64'(1));
      chk({tag, "_err_ready"}, 64'(in_ready), 64'(0));
      chk({tag, "_err_rstn"}, 64'(cpu_rstn), 64'(0));
      in_valid = 1'b0;
      chk({tag, "_err_xfers"}, 64'(n_xfer), 64'(2));
      chk({tag, "_err_writes"}, 64'(n_we), 64'(0));
      chk({tag, "_err_done"}, 64'(n_done), 64'(0));
      chk({tag, "_err_words"}, 64'(words_loaded), 64'(exp_words));
    end else begin
      for (int i = 0; i < 4 * n; i++) send_byte(byte_q[i], pick_stall(stall, rnd));
      wait_done(ok);
      chk({tag, "_done_seen"}, 64'(ok), 64'(1));
      chk({tag, "_n_writes"}, 64'(n_we), 64'(n));
      for (int i = 0; i < n && i < wr_data.size(); i++) begin
        chk($sformatf("%s_addr%0d", tag, i), 64'(wr_addr[i]), 64'((BASE_ADDR + i) % DEPTH));
        chk($sformatf("%s_data%0d", tag, i), 64'(wr_data[i]), 64'(model_word(i)));
      end
      if (exp_words > 0 && wr_data.size() > 0)
        chk({tag, "_word0"}, 64'(wr_data[0]), 64'(exp_w0));
      chk({tag, "_words"}, 64'(words_loaded), 64'(exp_words));
      chk({tag, "_err_clear"}, 64'(err), 64'(0));
      chk({tag, "_done_pulse"}, 64'(done), 64'(0));
      chk({tag, "_rstn_rel"}, 64'(cpu_rstn), 64'(1));
      chk({tag, "_done_count"}, 64'(n_done), 64'(1));
      last_evt = (n > 0 && wr_cyc.size() > 0) ? wr_cyc[wr_cyc.size()-1] : last_xfer_cyc;
      chk({tag, "_hold_len"}, 64'(done_cyc - last_evt), 64'(RST_HOLD + 1));
      chk({tag, "_rstn_low"}, 64'(low_cnt), 64'(done_cyc - start_cyc - 1));
      if (stall == 0 && !rnd)
        chk({tag, "_full_rate"}, 64'(done_cyc - start_cyc), 64'(3 + 5 * n + int'(RST_HOLD)));
      if (stall == 0 && !rnd && wr_cyc.size() >= 2)
        chk({tag, "_spacing"}, 64'(wr_cyc[1] - wr_cyc[0]), 64'(5));
    end
  endtask

  typedef struct {
    logic [15:0] len;
    int          stall;
    bit          plan;
    logic [7:0]  seed;
    bit          exp_err;
    int          exp_words;
    logic [31:0] exp_w0;
  } vec_t;

  vec_t vecs[9];

  initial begin
    bit ok;
    vecs[0] = '{16'd2,      0, 1'b1, 8'h00, 1'b0, 2,   32'h2008_0005};
    vecs[1] = '{16'd2,      3, 1'b1, 8'h00, 1'b0, 2,   32'h2008_0005};
    vecs[2] = '{16'd0,      0, 1'b0, 8'h00, 1'b0, 0,   32'h0000_0000};
    vecs[3] = '{16'h0081,   0, 1'b0, 8'h00, 1'b1, 0,   32'h0000_0000};
    vecs[4] = '{16'd1,      1, 1'b0, 8'h10, 1'b0, 1,   32'h1011_1213};
    vecs[5] = '{16'd128,    0, 1'b0, 8'hF0, 1'b0, 128, 32'hF0F1_F2F3};
    vecs[6] = '{16'h0100,   0, 1'b0, 8'h00, 1'b1, 0,   32'h0000_0000};
    vecs[7] = '{16'hFFFF,   2, 1'b0, 8'h00, 1'b1, 0,   32'h0000_0000};
    vecs[8] = '{16'd3,      2, 1'b0, 8'hFE, 1'b0, 3,   32'hFEFF_0001};

    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (3) tick();
    rst = 1'b0;
    clear_mon();
    in_valid = 1'b1;
    in_data  = 8'hA5;
    repeat (3) tick();
    chk("rst_in_ready", 64'(in_ready), 64'(0));
    chk("rst_mem_we", 64'(mem_we), 64'(0));
    chk("rst_mem_addr", 64'(mem_addr), 64'(BASE_ADDR));
    chk("rst_mem_wdata", 64'(mem_wdata), 64'(0));
    chk("rst_cpu_rstn", 64'(cpu_rstn), 64'(1));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_err", 64'(err), 64'(0));
    chk("rst_words", 64'(words_loaded), 64'(0));
    chk("rst_no_xfer", 64'(n_xfer), 64'(0));
    in_valid = 1'b0;

    for (int v = 0; v < 9; v++) begin
      byte_q.delete();
      if (vecs[v].plan) begin
        byte_q = '{8'h20, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h08, 8'h00, 8'h00};
      end else if (!vecs[v].exp_err) begin
        for (int k = 0; k < 4 * int'(vecs[v].len); k++) byte_q.push_back(vecs[v].seed + 8'(k));
      end
      run_load($sformatf("vec%0d", v), vecs[v].len, vecs[v].stall, 1'b0,
               vecs[v].exp_err, vecs[v].exp_words, vecs[v].exp_w0);
    end

    // start while a word is being assembled must not restart the load
    clear_mon();
    pulse_start();
    send_byte(8'h00, 0); send_byte(8'h01, 0);
    send_byte(8'hAA, 0); send_byte(8'hBB, 0);
    pulse_start();
    send_byte(8'hCC, 0); send_byte(8'hDD, 0);
    wait_done(ok);
    chk("ign_start_done", 64'(ok), 64'(1));
    chk("ign_start_writes", 64'(n_we), 64'(1));
    if (wr_data.size() > 0) begin
      chk("ign_start_data", 64'(wr_data[0]), 64'(32'hAABB_CCDD));
      chk("ign_start_addr", 64'(wr_addr[0]), 64'(BASE_ADDR));
    end
    chk("ign_start_words", 64'(words_loaded), 64'(1));

    // reset in the middle of the second word aborts without a write
    clear_mon();
    pulse_start();
    send_byte(8'h00, 0); send_byte(8'h02, 0);
    send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(8'h33, 0); send_byte(8'h44, 0);
    send_byte(8'h55, 0); send_byte(8'h66, 0);
    chk("abort_words_before", 64'(words_loaded), 64'(1));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_in_ready", 64'(in_ready), 64'(0));
    chk("abort_mem_we", 64'(mem_we), 64'(0));
    chk("abort_mem_addr", 64'(mem_addr), 64'(BASE_ADDR));
    chk("abort_mem_wdata", 64'(mem_wdata), 64'(0));
    chk("abort_cpu_rstn", 64'(cpu_rstn), 64'(1));
    chk("abort_done", 64'(done), 64'(0));
    chk("abort_err", 64'(err), 64'(0));
    chk("abort_words", 64'(words_loaded), 64'(0));
    in_valid = 1'b1; in_data = 8'h77;
    repeat (3) tick();
    in_valid = 1'b0;
    chk("abort_writes", 64'(n_we), 64'(1));
    chk("abort_no_done", 64'(n_done), 64'(0));

    for (int r = 0; r < 12; r++) begin
      logic [15:0] len;
      bit          e;
      len = ($urandom_range(0, 5) == 0) ? 16'($urandom_range(129, 400)) : 16'($urandom_range(0, 16));
      e   = int'(len) > int'(DEPTH);
      byte_q.delete();
      if (!e) for (int k = 0; k < 4 * int'(len); k++) byte_q.push_back(8'($urandom));
      run_load($sformatf("rnd%0d", r), len, 2, 1'b1, e, e ? 0 : int'(len),
               (!e && len > 0) ? model_word(0) : 32'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

endmodule
